// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package dmem_pkg;

   localparam int unsigned DMEM_ADDR_W       = 7;
   localparam int unsigned DMEM_DATA_W       = 32;
   localparam int unsigned DMEM_STARVE_LIMIT = 3;

   typedef logic [1:0] dmem_state_t;

   localparam dmem_state_t IDLE = 2'd0;
   localparam dmem_state_t P_RD = 2'd1;
   localparam dmem_state_t E_RD = 2'd2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the RAM (slave).
interface dmem_arbiter_if
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DATA_W = DMEM_DATA_W
);

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_en,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_en,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the 128x32 data memory between the pipeline MEM stage and an
// external loader port, with a bounded-starvation guarantee for the latter.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W       = DMEM_ADDR_W,
   parameter int unsigned DATA_W       = DMEM_DATA_W,
   parameter int unsigned STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              p_req_i,
   input  logic              p_we_i,
   input  logic [ADDR_W-1:0] p_addr_i,
   input  logic [DATA_W-1:0] p_wdata_i,
   output logic [DATA_W-1:0] p_rdata_o,
   output logic              p_stall_o,

   input  logic              e_req_i,
   input  logic              e_we_i,
   input  logic [ADDR_W-1:0] e_addr_i,
   input  logic [DATA_W-1:0] e_wdata_i,
   output logic              e_gnt_o,
   output logic              e_rvalid_o,
   output logic [DATA_W-1:0] e_rdata_o,

   dmem_arbiter_if.master    mem_if
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   dmem_state_t      state_q, state_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   logic p_elig;
   logic starve;
   logic gnt_e;
   logic gnt_p;

   // A held p_req during P_RD is the load completing, not a new access.
   assign p_elig = p_req_i && (state_q != P_RD);
   assign starve = (starve_cnt_q == CNT_MAX);

   // Grants are masked by rst so every output is quiet while reset is held.
   assign gnt_e = !rst && e_req_i && (starve || !p_elig);
   assign gnt_p = !rst && !gnt_e && p_elig;

   always_comb begin
      mem_if.mem_en    = 1'b0;
      mem_if.mem_we    = 1'b0;
      mem_if.mem_addr  = '0;
      mem_if.mem_wdata = '0;
      if (gnt_e) begin
         mem_if.mem_en    = 1'b1;
         mem_if.mem_we    = e_we_i;
         mem_if.mem_addr  = e_addr_i;
         mem_if.mem_wdata = e_wdata_i;
      end else if (gnt_p) begin
         mem_if.mem_en    = 1'b1;
         mem_if.mem_we    = p_we_i;
         mem_if.mem_addr  = p_addr_i;
         mem_if.mem_wdata = p_wdata_i;
      end
   end

   assign p_stall_o  = !rst && p_elig && !(gnt_p && p_we_i);
   assign e_gnt_o    = gnt_e;
   assign p_rdata_o  = (state_q == P_RD) ? mem_if.mem_rdata : '0;
   assign e_rvalid_o = (state_q == E_RD);
   assign e_rdata_o  = (state_q == E_RD) ? mem_if.mem_rdata : '0;

   always_comb begin
      state_d = IDLE;
      if (gnt_p && !p_we_i) begin
         state_d = P_RD;
      end else if (gnt_e && !e_we_i) begin
         state_d = E_RD;
      end
   end

   always_comb begin
      starve_cnt_d = '0;
      if (gnt_e) begin
         starve_cnt_d = '0;
      end else if (e_req_i) begin
         starve_cnt_d = starve ? starve_cnt_q : starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter and sequencer for the 128x32 data memory. It shares the memory between two requesters: the pipeline MEM stage (lw/sw) and an external loader/debug port. It issues one access per cycle and returns read data one cycle after issue. It drives a stall to hold the XM register, and it guarantees the external port forward progress through a bounded-starvation rule.

## Interface
Parameters:
- ADDR_W, 7, word address width (128 words)
- DATA_W, 32, data width
- STARVE_LIMIT, 3, max consecutive cycles a pending e_req may be denied (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- p_req  in  1  pipeline access request (held until not stalled)
- p_we  in  1  1=store, 0=load
- p_addr  in  ADDR_W  pipeline word address
- p_wdata  in  DATA_W  store data
- p_rdata  out  DATA_W  load data, valid in the cycle p_stall falls after a load
- p_stall  out  1  hold XM register this cycle
- e_req  in  1  external request; e_we/e_addr/e_wdata stable until e_gnt
- e_we  in  1  external write enable
- e_addr  in  ADDR_W  external address
- e_wdata  in  DATA_W  external write data
- e_gnt  out  1  external access issued this cycle
- e_rvalid  out  1  external read data valid (cycle after read grant)
- e_rdata  out  DATA_W  external read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, valid the cycle after mem_en && !mem_we

## Operation
- FSM states: IDLE (no read outstanding), P_RD (pipeline read returning this cycle), E_RD (external read returning this cycle).
- p_elig = p_req && state != P_RD. A held p_req during P_RD is the completing load and is never reissued.
- starve = (starve_cnt == STARVE_LIMIT).
- Grant each cycle:
  - ext if e_req && (starve || !p_elig)
  - else pipe if p_elig
  - else none
- mem_* are driven combinationally from the granted requester. With no grant, mem_en=0 and all other mem_* outputs are 0.
- p_stall = p_elig && !(pipe granted && p_we). A store completes in its grant cycle. A load stalls in its grant cycle and completes in P_RD. A denied request stalls.
- p_rdata = mem_rdata in P_RD, else 0. e_rvalid = (state==E_RD); e_rdata = mem_rdata in E_RD, else 0.
- Next state: P_RD on pipe read grant, E_RD on ext read grant, else IDLE. A grant is legal in any state, since the port is free once a read is returning.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - 0 on ext grant
  - saturating +1 if e_req and not granted
  - 0 if !e_req

## Timing
- Reset values: state=IDLE, starve_cnt=0. While rst=1, all outputs are 0 (no grants, p_stall=0) regardless of requests.
- Store latency 0 stall cycles when granted. Load latency 1 stall cycle.
- External read: e_gnt at cycle N, e_rvalid/e_rdata at N+1. External write takes effect at N.
- Simultaneous requests: the pipeline wins unless starve. When ext wins, p_stall=1 for that cycle.
- Reset asserted mid-operation drops the outstanding read: no e_rvalid, p_rdata=0 after release.

## Structure
- Shared package dmem_pkg holds DMEM_ADDR_W=7, DMEM_DATA_W=32, the state enum {IDLE,P_RD,E_RD}, and the default STARVE_LIMIT.
- No internal sub-modules. The storage array is a separate module, dmem_ram (128x32, sync read), instantiated beside the arbiter by the MEM stage.

## Test plan
- Preload mem[5]=0xDEADBEEF, then pipeline lw addr 5. Required: cycle 0 mem_en=1, mem_we=0, p_stall=1. Cycle 1 p_rdata=0xDEADBEEF, p_stall=0, no reissue.
- Pipeline sw addr 3 data 0x12345678. Required: mem_we=1 and p_stall=0 in the same cycle; a following lw addr 3 returns 0x12345678.
- Pipeline sw and external read of addr 3 requested in the same cycle. Required: pipe granted with e_gnt=0; next cycle e_gnt=1; the cycle after, e_rvalid=1 with e_rdata=0x12345678.
- STARVE_LIMIT=3, continuous pipeline stores plus a held e_req write. Required: e_gnt=0 for 3 cycles; cycle 4 e_gnt=1, p_stall=1, starve_cnt returns to 0.
- Pipeline lw issued, then e_req read asserted during P_RD. Required: in P_RD, p_rdata is valid and e_gnt=1; next cycle e_rvalid=1.
- rst pulsed asynchronously during E_RD. Required: outputs 0 immediately, no e_rvalid after release, state=IDLE.
